mlp_w_sram_arb: RTL and testbench

//  Shares the single-port MLP weight SRAM between two requesters:
//  - the compute FSM: read-only weight fetch
//  - the host/init loader: read and write

---
 rtl/mlp_w_sram_arb.sv | 110 +++++++++++
 tb/tb_mlp_w_sram_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_w_sram_arb.sv
// Arbiter for the single-port MLP weight SRAM: compute reads have priority, host
// read/write gets forced through after MAX_WAIT consecutive denied cycles.
module mlp_w_sram_arb #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              c_req_valid_i,
  output logic              c_req_ready_o,
  input  logic [ADDR_W-1:0] c_addr_i,
  output logic              c_rsp_valid_o,
  output logic [DATA_W-1:0] c_rsp_data_o,

  input  logic              h_req_valid_i,
  output logic              h_req_ready_o,
  input  logic              h_we_i,
  input  logic [ADDR_W-1:0] h_addr_i,
  input  logic [DATA_W-1:0] h_wdata_i,
  output logic              h_rsp_valid_o,
  output logic [DATA_W-1:0] h_rsp_data_o,

  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  // Handshake: a request is accepted on a rising edge where valid && ready.
  // ready is a same-cycle combinational grant; requesters hold addr/data while
  // valid && !ready. Responses are never backpressured.

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             c_pend_q, c_pend_d;
  logic             h_pend_q, h_pend_d;

  logic host_forced;
  logic c_gnt;
  logic h_gnt;

  // Grant: suppressed entirely while reset is asserted.
  always_comb begin
    host_forced = h_req_valid_i && (wait_cnt_q == WAIT_MAX);
    c_gnt       = !rst_i && c_req_valid_i && !host_forced;
    h_gnt       = !rst_i && h_req_valid_i && !c_gnt;
  end

  assign c_req_ready_o = c_gnt;
  assign h_req_ready_o = h_gnt;

  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (c_gnt) begin
      sram_en_o   = 1'b1;
      sram_addr_o = c_addr_i;
    end else if (h_gnt) begin
      sram_en_o   = 1'b1;
      sram_we_o   = h_we_i;
      sram_addr_o = h_addr_i;
      if (h_we_i) begin
        sram_wdata_o = h_wdata_i;
      end
    end
  end

  // Starvation counter: counts consecutive denied host cycles, saturating.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!h_req_valid_i || h_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    c_pend_d = c_gnt;
    h_pend_d = h_gnt && !h_we_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      c_pend_q   <= 1'b0;
      h_pend_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      c_pend_q   <= c_pend_d;
      h_pend_q   <= h_pend_d;
    end
  end

  // A response already in flight when reset rises is dropped, not presented.
  always_comb begin
    c_rsp_valid_o = c_pend_q && !rst_i;
    h_rsp_valid_o = h_pend_q && !rst_i;
    c_rsp_data_o  = c_rsp_valid_o ? sram_rdata_i : '0;
    h_rsp_data_o  = h_rsp_valid_o ? sram_rdata_i : '0;
  end

endmodule

// File: tb/tb_mlp_w_sram_arb.sv
// Directed bench for mlp_w_sram_arb: one DUT with MAX_WAIT=4 and one with
// MAX_WAIT=1, each backed by a simple one-cycle-latency SRAM model.
module tb_mlp_w_sram_arb;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A (MAX_WAIT=4) ----------------
  logic              cv, cr, crv, hv, hr, hwe, hrv, s_en, s_we;
  logic [ADDR_W-1:0] ca, ha, s_addr;
  logic [DATA_W-1:0] crd, hwd, hrd, s_wd, s_rd;

  mlp_w_sram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .c_req_valid_i(cv), .c_req_ready_o(cr), .c_addr_i(ca),
    .c_rsp_valid_o(crv), .c_rsp_data_o(crd),
    .h_req_valid_i(hv), .h_req_ready_o(hr), .h_we_i(hwe), .h_addr_i(ha),
    .h_wdata_i(hwd), .h_rsp_valid_o(hrv), .h_rsp_data_o(hrd),
    .sram_en_o(s_en), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_wdata_o(s_wd), .sram_rdata_i(s_rd)
  );

  // ---------------- DUT B (MAX_WAIT=1) ----------------
  logic              cv2, cr2, crv2, hv2, hr2, hwe2, hrv2, s_en2, s_we2;
  logic [ADDR_W-1:0] ca2, ha2, s_addr2;
  logic [DATA_W-1:0] crd2, hwd2, hrd2, s_wd2, s_rd2;

  mlp_w_sram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .c_req_valid_i(cv2), .c_req_ready_o(cr2), .c_addr_i(ca2),
    .c_rsp_valid_o(crv2), .c_rsp_data_o(crd2),
    .h_req_valid_i(hv2), .h_req_ready_o(hr2), .h_we_i(hwe2), .h_addr_i(ha2),
    .h_wdata_i(hwd2), .h_rsp_valid_o(hrv2), .h_rsp_data_o(hrd2),
    .sram_en_o(s_en2), .sram_we_o(s_we2), .sram_addr_o(s_addr2),
    .sram_wdata_o(s_wd2), .sram_rdata_i(s_rd2)
  );

  // ---------------- SRAM models ----------------
  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] mem2 [2**ADDR_W];

  function automatic logic [DATA_W-1:0] init_val(input int a);
    logic [31:0] av;
    av = a;
    return av[7:0] ^ 8'h3C;
  endfunction

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i]  = init_val(i);
      mem2[i] = init_val(i);
    end
    s_rd  = '0;
    s_rd2 = '0;
  end

  always @(posedge clk) begin
    if (s_en) begin
      if (s_we) mem[s_addr] <= s_wd;
      else      s_rd <= mem[s_addr];
    end
    if (s_en2) begin
      if (s_we2) mem2[s_addr2] <= s_wd2;
      else       s_rd2 <= mem2[s_addr2];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cv = 0; ca = '0; hv = 0; hwe = 0; ha = '0; hwd = '0;
    cv2 = 0; ca2 = '0; hv2 = 0; hwe2 = 0; ha2 = '0; hwd2 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_all();
    rst = 1;
    cyc(); cyc();
    cv = 1; hv = 1; ca = 11'd5; ha = 11'd6;
    cv2 = 1; hv2 = 1;
    #1;
    n_checks++; if (cr !== 1'b0)   begin n_fail++; $display("FAIL reset_c_ready got %b exp 0", cr); end
    n_checks++; if (hr !== 1'b0)   begin n_fail++; $display("FAIL reset_h_ready got %b exp 0", hr); end
    n_checks++; if (s_en !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en got %b exp 0", s_en); end
    n_checks++; if (crv !== 1'b0 || hrv !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got c=%b h=%b exp 0 0", crv, hrv); end
    n_checks++; if (cr2 !== 1'b0 || hr2 !== 1'b0 || s_en2 !== 1'b0) begin n_fail++; $display("FAIL reset_dut2 got cr=%b hr=%b en=%b exp 0 0 0", cr2, hr2, s_en2); end
    cyc();
    idle_all();
    rst = 0;
    cyc();
    n_checks++; if (crv !== 1'b0 || hrv !== 1'b0) begin n_fail++; $display("FAIL post_reset_rsp got c=%b h=%b exp 0 0", crv, hrv); end
  endtask

  task automatic test_compute_reads();
    cyc();
    cv = 1; ca = 11'h005; #1;
    n_checks++; if (cr !== 1'b1 || s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 11'h005)
      begin n_fail++; $display("FAIL c_rd0_issue got rdy=%b en=%b we=%b addr=%h exp 1 1 0 005", cr, s_en, s_we, s_addr); end
    cyc();
    ca = 11'h006; #1;
    n_checks++; if (cr !== 1'b1 || s_en !== 1'b1 || s_addr !== 11'h006)
      begin n_fail++; $display("FAIL c_rd1_issue got rdy=%b en=%b addr=%h exp 1 1 006", cr, s_en, s_addr); end
    n_checks++; if (crv !== 1'b1 || crd !== 8'h39)
      begin n_fail++; $display("FAIL c_rd0_rsp got v=%b d=%h exp 1 39", crv, crd); end
    n_checks++; if (hrv !== 1'b0 || hrd !== 8'h00)
      begin n_fail++; $display("FAIL c_rd0_hport got v=%b d=%h exp 0 00", hrv, hrd); end
    cyc();
    cv = 0; #1;
    n_checks++; if (crv !== 1'b1 || crd !== 8'h3A)
      begin n_fail++; $display("FAIL c_rd1_rsp got v=%b d=%h exp 1 3a", crv, crd); end
    n_checks++; if (s_en !== 1'b0 || s_addr !== 11'h000 || hrv !== 1'b0)
      begin n_fail++; $display("FAIL c_idle_sram got en=%b addr=%h hv=%b exp 0 000 0", s_en, s_addr, hrv); end
    cyc();
    n_checks++; if (crv !== 1'b0) begin n_fail++; $display("FAIL c_rsp_drop got %b exp 0", crv); end
  endtask

  task automatic test_host_write_read();
    cyc();
    hv = 1; hwe = 1; ha = 11'h7FF; hwd = 8'hA5; #1;
    n_checks++; if (hr !== 1'b1 || s_en !== 1'b1 || s_we !== 1'b1 || s_addr !== 11'h7FF || s_wd !== 8'hA5)
      begin n_fail++; $display("FAIL h_wr_issue got rdy=%b en=%b we=%b addr=%h wd=%h exp 1 1 1 7ff a5", hr, s_en, s_we, s_addr, s_wd); end
    cyc();
    hwe = 0; hwd = 8'h00; #1;
    n_checks++; if (hr !== 1'b1 || s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 11'h7FF)
      begin n_fail++; $display("FAIL h_rd_issue got rdy=%b en=%b we=%b addr=%h exp 1 1 0 7ff", hr, s_en, s_we, s_addr); end
    n_checks++; if (hrv !== 1'b0) begin n_fail++; $display("FAIL h_wr_no_rsp got %b exp 0", hrv); end
    cyc();
    hv = 0; ha = '0; #1;
    n_checks++; if (hrv !== 1'b1 || hrd !== 8'hA5)
      begin n_fail++; $display("FAIL h_rd_rsp got v=%b d=%h exp 1 a5", hrv, hrd); end
    n_checks++; if (crv !== 1'b0 || crd !== 8'h00)
      begin n_fail++; $display("FAIL h_rd_cport got v=%b d=%h exp 0 00", crv, crd); end
  endtask

  // Both requesters valid every cycle: C C C C H repeating.
  task automatic test_starvation();
    logic prev_c;
    int   prev_a;
    prev_c = 0;
    prev_a = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      cv = 1; ca = 11'(100 + i);
      hv = 1; hwe = 0; ha = 11'(200 + i);
      #1;
      n_checks++; if (cr !== (i % 5 != 4) || hr !== (i % 5 == 4))
        begin n_fail++; $display("FAIL starve_grant[%0d] got c=%b h=%b exp c=%b", i, cr, hr, (i % 5 != 4)); end
      if (i > 0) begin
        n_checks++;
        if (prev_c) begin
          if (crv !== 1'b1 || crd !== init_val(prev_a) || hrv !== 1'b0)
            begin n_fail++; $display("FAIL starve_rsp[%0d] got cv=%b cd=%h hv=%b exp 1 %h 0", i, crv, crd, hrv, init_val(prev_a)); end
        end else begin
          if (hrv !== 1'b1 || hrd !== init_val(prev_a) || crv !== 1'b0)
            begin n_fail++; $display("FAIL starve_rsp[%0d] got hv=%b hd=%h cv=%b exp 1 %h 0", i, hrv, hrd, crv, init_val(prev_a)); end
        end
      end
      prev_c = (i % 5 != 4);
      prev_a = prev_c ? 100 + i : 200 + i;
    end
    cyc();
    cv = 0; hv = 0; #1;
    n_checks++; if (hrv !== 1'b1 || hrd !== init_val(209))
      begin n_fail++; $display("FAIL starve_last_rsp got v=%b d=%h exp 1 %h", hrv, hrd, init_val(209)); end
  endtask

  // Dropping host valid clears the wait count; it then waits 4 full cycles again.
  task automatic test_wait_restart();
    for (int i = 0; i < 2; i++) begin
      cyc();
      cv = 1; ca = 11'd1; hv = 1; hwe = 0; ha = 11'd2; #1;
      n_checks++; if (hr !== 1'b0) begin n_fail++; $display("FAIL restart_deny[%0d] got %b exp 0", i, hr); end
    end
    cyc();
    hv = 0; #1;
    n_checks++; if (cr !== 1'b1 || hr !== 1'b0) begin n_fail++; $display("FAIL restart_drop got c=%b h=%b exp 1 0", cr, hr); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      hv = 1; #1;
      n_checks++; if (hr !== (i == 4) || cr !== (i != 4))
        begin n_fail++; $display("FAIL restart_wait[%0d] got c=%b h=%b exp h=%b", i, cr, hr, (i == 4)); end
    end
    cyc();
    cv = 0; hv = 0;
    cyc();
  endtask

  task automatic test_reset_inflight();
    cyc();
    cv = 1; ca = 11'h005; #1;
    n_checks++; if (cr !== 1'b1) begin n_fail++; $display("FAIL mid_rst_accept got %b exp 1", cr); end
    cyc();
    rst = 1; ca = 11'h006; hv = 1; #1;
    n_checks++; if (crv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_drop got %b exp 0", crv); end
    n_checks++; if (cr !== 1'b0 || hr !== 1'b0 || s_en !== 1'b0)
      begin n_fail++; $display("FAIL mid_rst_ready got c=%b h=%b en=%b exp 0 0 0", cr, hr, s_en); end
    cyc();
    rst = 0; hv = 0; #1;
    n_checks++; if (cr !== 1'b1 || s_en !== 1'b1 || s_addr !== 11'h006)
      begin n_fail++; $display("FAIL mid_rst_resume got c=%b en=%b addr=%h exp 1 1 006", cr, s_en, s_addr); end
    n_checks++; if (crv !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_rsp got %b exp 0", crv); end
    cyc();
    cv = 0; #1;
    n_checks++; if (crv !== 1'b1 || crd !== 8'h3A)
      begin n_fail++; $display("FAIL mid_rst_rsp got v=%b d=%h exp 1 3a", crv, crd); end
    cyc();
  endtask

  // MAX_WAIT=1: grants alternate C H C H ...
  task automatic test_max_wait_one();
    logic prev_c;
    int   prev_a;
    prev_c = 0;
    prev_a = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      cv2 = 1; ca2 = 11'(10 + i); hv2 = 1; hwe2 = 0; ha2 = 11'(20 + i); #1;
      n_checks++; if (cr2 !== (i % 2 == 0) || hr2 !== (i % 2 == 1))
        begin n_fail++; $display("FAIL alt_grant[%0d] got c=%b h=%b exp c=%b", i, cr2, hr2, (i % 2 == 0)); end
      if (i > 0) begin
        n_checks++;
        if (prev_c) begin
          if (crv2 !== 1'b1 || crd2 !== init_val(prev_a) || hrv2 !== 1'b0 || hrd2 !== 8'h00)
            begin n_fail++; $display("FAIL alt_rsp[%0d] got cv=%b cd=%h hv=%b hd=%h exp 1 %h 0 00", i, crv2, crd2, hrv2, hrd2, init_val(prev_a)); end
        end else begin
          if (hrv2 !== 1'b1 || hrd2 !== init_val(prev_a) || crv2 !== 1'b0 || crd2 !== 8'h00)
            begin n_fail++; $display("FAIL alt_rsp[%0d] got hv=%b hd=%h cv=%b cd=%h exp 1 %h 0 00", i, hrv2, hrd2, crv2, crd2, init_val(prev_a)); end
        end
      end
      prev_c = (i % 2 == 0);
      prev_a = prev_c ? 10 + i : 20 + i;
    end
    cyc();
    cv2 = 0; hv2 = 0; #1;
    n_checks++; if (hrv2 !== 1'b1 || hrd2 !== init_val(25))
      begin n_fail++; $display("FAIL alt_last_rsp got v=%b d=%h exp 1 %h", hrv2, hrd2, init_val(25)); end
    cyc();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_all();
    test_reset();
    test_compute_reads();
    test_host_write_read();
    test_starvation();
    test_wait_restart();
    test_reset_inflight();
    test_max_wait_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
